// File: rtl/l0_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l0_pkg : shared mode encodings and width helper for the L0 buffer  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package l0_pkg;

  localparam logic L0_MODE_BCAST = 1'b0;
  localparam logic L0_MODE_SKEW  = 1'b1;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l0_row_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l0_row_fifo : single-clock per-row FIFO with registered read data  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module l0_row_fifo
  import l0_pkg::*;
#(
  parameter int BW    = 4,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [BW-1:0]          din,
  output logic [BW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [BW-1:0] dout_q;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign dout      = dout_q;
  // Full/empty come from pre-edge state, so same-cycle push/pop never rescue each other.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem[rd_ptr_q];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/l0_skew_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | l0_skew_buffer : ROW-wide L0 input buffer, broadcast/skewed reads  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module l0_skew_buffer
  import l0_pkg::*;
#(
  parameter int ROW   = 8,
  parameter int BW    = 4,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   wr,
  input  logic [ROW*BW-1:0]      in,
  input  logic                   rd,
  output logic [ROW*BW-1:0]      out,
  output logic [ROW-1:0]         out_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_empty,
  output logic [clog2(DEPTH):0]  o_count,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int CW = clog2(DEPTH) + 1;

  logic [ROW-1:0]         rd_en_q,     rd_en_d;
  logic                   mode_q,      mode_d;
  logic [ROW-1:0]         out_valid_q, out_valid_d;
  logic                   ovf_q,       ovf_d;
  logic                   unf_q,       unf_d;

  logic [ROW-1:0]         w_row_full;
  logic [ROW-1:0]         w_row_empty;
  logic [ROW-1:0][BW-1:0] w_row_dout;
  logic [ROW-1:0][CW-1:0] w_row_count;
  logic [(ROW-1)*CW-1:0]  w_count_unused;
  logic                   w_any_full;
  logic                   w_push;

  assign w_any_full = |w_row_full;
  // A write is all-or-nothing so every row keeps the same fill level.
  assign w_push     = wr && !w_any_full;

  generate
    for (genvar i = 0; i < ROW; i++) begin : g_row
      l0_row_fifo #(
        .BW    (BW),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (rd_en_q[i]),
        .din   (in[i*BW +: BW]),
        .dout  (w_row_dout[i]),
        .full  (w_row_full[i]),
        .empty (w_row_empty[i]),
        .count (w_row_count[i])
      );
    end
  endgenerate

  always_comb begin
    rd_en_d     = {ROW{rd}};
    mode_d      = mode_q;
    out_valid_d = rd_en_q & ~w_row_empty;
    ovf_d       = ovf_q | (wr & w_any_full);
    unf_d       = unf_q | (|(rd_en_q & w_row_empty));
    if (mode_q == L0_MODE_SKEW) begin
      rd_en_d = {rd_en_q[ROW-2:0], rd};
    end
    // Pattern may only change with no wavefront launching or in flight.
    if (!rd && (rd_en_q == '0)) begin
      mode_d = mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q     <= '0;
      mode_q      <= L0_MODE_BCAST;
      out_valid_q <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      rd_en_q     <= rd_en_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign out            = w_row_dout;
  assign out_valid      = out_valid_q;
  assign o_full         = w_any_full;
  assign o_ready        = ~w_any_full;
  assign o_empty        = &w_row_empty;
  assign o_count        = w_row_count[ROW-1];
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;
  assign w_count_unused = w_row_count[ROW-2:0];

endmodule
`default_nettype wire

// File: tb/tb_l0_skew_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_l0_skew_buffer : randomized scoreboard bench for l0_skew_buffer |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_l0_skew_buffer;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                mode;
  logic                wr;
  logic [ROW*BW-1:0]   din;
  logic                rd;
  logic [ROW*BW-1:0]   out;
  logic [ROW-1:0]      out_valid;
  logic                o_full;
  logic                o_ready;
  logic                o_empty;
  logic [CW-1:0]       o_count;
  logic                o_overflow;
  logic                o_underflow;

  always #5 clk = ~clk;

  l0_skew_buffer #(
    .ROW   (ROW),
    .BW    (BW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .wr          (wr),
    .in          (din),
    .rd          (rd),
    .out         (out),
    .out_valid   (out_valid),
    .o_full      (o_full),
    .o_ready     (o_ready),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  typedef struct {
    int            cyc;
    int            row;
    logic [BW-1:0] val;
  } exp_t;

  typedef struct {
    int cyc;
    bit rst;
    bit full;
    bit empty;
    int count;
    bit ovf;
    bit unf;
  } st_t;

  exp_t dq[$];
  st_t  sq[$];

  // Reference model: per-row queues plus the cycle at which each row is due to pop.
  logic [BW-1:0] rowq [ROW][$];
  int            pend [ROW][$];
  bit            m_mode;
  bit            m_ovf;
  bit            m_unf;
  int            t = 0;

  int nchecks = 0;
  int nerr    = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
    end
  endfunction

  task automatic model(input bit rst_v, input bit wr_v, input logic [ROW*BW-1:0] d,
                       input bit rd_v, input bit mode_v);
    st_t s;
    bit  any_full;
    bit  any_en;
    bit  emp [ROW];
    exp_t e;
    any_full = 1'b0;
    any_en   = 1'b0;
    if (rst_v) begin
      for (int i = 0; i < ROW; i++) begin
        rowq[i].delete();
        pend[i].delete();
      end
      m_mode = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      while (dq.size() > 0 && dq[$].cyc > t) void'(dq.pop_back());
      s.rst = 1'b1;
    end else begin
      for (int i = 0; i < ROW; i++) begin
        if (rowq[i].size() == DEPTH) any_full = 1'b1;
        emp[i] = (rowq[i].size() == 0);
      end
      for (int i = 0; i < ROW; i++) begin
        if (pend[i].size() > 0 && pend[i][0] == t) begin
          void'(pend[i].pop_front());
          any_en = 1'b1;
          if (!emp[i]) begin
            e.cyc = t + 1;
            e.row = i;
            e.val = rowq[i].pop_front();
            dq.push_back(e);
          end else begin
            m_unf = 1'b1;
          end
        end
      end
      if (wr_v) begin
        if (any_full) m_ovf = 1'b1;
        else for (int i = 0; i < ROW; i++) rowq[i].push_back(d[i*BW +: BW]);
      end
      if (rd_v) begin
        for (int i = 0; i < ROW; i++) pend[i].push_back(m_mode ? t + 1 + i : t + 1);
      end
      if (!rd_v && !any_en) m_mode = mode_v;
      s.rst = 1'b0;
    end
    s.cyc   = t + 1;
    s.full  = 1'b0;
    s.empty = 1'b1;
    for (int i = 0; i < ROW; i++) begin
      if (rowq[i].size() == DEPTH) s.full = 1'b1;
      if (rowq[i].size() != 0) s.empty = 1'b0;
    end
    s.count = rowq[ROW-1].size();
    s.ovf   = m_ovf;
    s.unf   = m_unf;
    sq.push_back(s);
  endtask

  task automatic step(input bit rst_v, input bit wr_v, input logic [ROW*BW-1:0] d,
                      input bit rd_v, input bit mode_v);
    @(posedge clk);
    #1;
    t++;
    reset = rst_v;
    wr    = wr_v;
    din   = d;
    rd    = rd_v;
    mode  = mode_v;
    model(rst_v, wr_v, d, rd_v, mode_v);
  endtask

  task automatic idle(input int n, input bit mode_v);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, mode_v);
  endtask

  // Monitor: compares the DUT against whatever the model scheduled for this cycle.
  st_t                 mon_s;
  logic [ROW-1:0]      mon_ev;
  logic [ROW*BW-1:0]   last_out = '0;

  always @(negedge clk) begin
    if (sq.size() > 0 && sq[0].cyc == t) begin
      mon_s  = sq.pop_front();
      mon_ev = '0;
      if (mon_s.rst) last_out = '0;
      while (dq.size() > 0 && dq[0].cyc <= t) begin
        if (dq[0].cyc < t) chk("stale_expect", 64'(dq[0].cyc), 64'(t));
        mon_ev[dq[0].row] = 1'b1;
        last_out[dq[0].row*BW +: BW] = dq[0].val;
        void'(dq.pop_front());
      end
      chk("out_valid",   64'(out_valid),   64'(mon_ev));
      chk("out",         64'(out),         64'(last_out));
      chk("o_full",      64'(o_full),      64'(mon_s.full));
      chk("o_ready",     64'(o_ready),     64'(!mon_s.full));
      chk("o_empty",     64'(o_empty),     64'(mon_s.empty));
      chk("o_count",     64'(o_count),     64'(mon_s.count));
      chk("o_overflow",  64'(o_overflow),  64'(mon_s.ovf));
      chk("o_underflow", 64'(o_underflow), 64'(mon_s.unf));
    end
  end

  bit   rm;
  int   r;
  logic [ROW*BW-1:0] rdat;

  initial begin
    reset = 1'b1;
    mode  = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    din   = '0;

    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Broadcast read of three entries.
    step(1'b0, 1'b1, 32'h76543210, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hFEDCBA98, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h13572468, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b0);

    // Skewed wavefronts, back to back.
    step(1'b0, 1'b1, 32'h76543210, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'hFEDCBA98, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h13572468, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(ROW + 4, 1'b0);

    // Fill to full, overflow once, then drain in broadcast.
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, {ROW{BW'(k)}} ^ 32'h0F0F0F0F, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Skewed read on an empty buffer.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(ROW + 2, 1'b1);

    // Mode toggled while a skew wavefront is in flight.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h89ABCDEF + 32'(k), 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(ROW + 2, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(4, 1'b0);

    // Reset in the middle of a skew wavefront.
    idle(2, 1'b1);
    step(1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    idle(4, 1'b0);

    // Randomized traffic.
    rm = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      r    = int'($urandom_range(0, 199));
      rdat = ROW*BW'($urandom());
      if ($urandom_range(0, 9) == 0) rm = ~rm;
      step(r == 0, $urandom_range(0, 99) < 45, rdat, $urandom_range(0, 99) < 35, rm);
    end
    idle(ROW + 4, 1'b0);

    chk("pending_outputs", 64'(dq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
`default_nettype wire
